// File: rtl/hist_pkg.sv
// hist_pkg: shared definitions for the histogram readout statistics block.
//   - default bin-count / bin-index widths matching the histogram core
//   - frame FSM state encoding
//   - hist_stats_t: result record at the default widths, for consumers that
//     bundle the hist_stats outputs into a single bus
package hist_pkg;

    localparam int HIST_BIN_W = 8;   // core data_out width
    localparam int HIST_IDX_W = 5;   // up to 32 bins per frame
    localparam int HIST_SUM_W = HIST_BIN_W + HIST_IDX_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } hist_state_e;

    typedef struct packed {
        logic [HIST_IDX_W-1:0] peak_idx;
        logic [HIST_BIN_W-1:0] peak_count;
        logic [HIST_SUM_W-1:0] total;
        logic [HIST_IDX_W:0]   nonzero_bins;
        logic                  idx_ovf;
    } hist_stats_t;

endpackage

// File: rtl/hist_peak_tracker.sv
// hist_peak_tracker: running arg-max over a frame of bin counts.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   i_beat         a bin is presented this cycle
//   i_first        this bin is the first of a frame (loads instead of compares)
//   i_idx          index of the presented bin
//   i_count        count of the presented bin
//   o_nxt_idx      peak index including the presented bin (combinational)
//   o_nxt_count    peak count including the presented bin (combinational)
// The "next" view lets the parent capture a final result on the last beat
// without an extra cycle.
module hist_peak_tracker
    import hist_pkg::*;
#(
    parameter int BIN_W = HIST_BIN_W,
    parameter int IDX_W = HIST_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_beat,
    input  logic             i_first,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [BIN_W-1:0] i_count,
    output logic [IDX_W-1:0] o_nxt_idx,
    output logic [BIN_W-1:0] o_nxt_count
);

    logic [IDX_W-1:0] r_idx;
    logic [BIN_W-1:0] r_count;
    logic             w_replace;

    // Strictly greater only: on a tie the earlier (lower) index is kept.
    assign w_replace   = i_first || (i_count > r_count);
    assign o_nxt_idx   = w_replace ? i_idx   : r_idx;
    assign o_nxt_count = w_replace ? i_count : r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_count <= '0;
        end else if (i_beat) begin
            r_idx   <= o_nxt_idx;
            r_count <= o_nxt_count;
        end
    end

endmodule

// File: rtl/hist_stats.sv
// hist_stats: reduces each histogram readout frame to peak index/count,
// saturating total, and non-zero bin count, then holds the result behind a
// valid/ack register while the next frame accumulates.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   bin_count             current bin count (with bin_valid)
//   bin_valid, bin_last   beat strobe / final bin of frame
//   stats_ack             consumer has taken the result
//   stats_valid           unread result present
//   peak_idx, peak_count  highest bin (lowest index on ties)
//   total                 saturating sum of counts
//   nonzero_bins          bins with count > 0, saturating at 2^IDX_W
//   idx_ovf               frame exceeded 2^IDX_W bins
//   overrun               an unread result was overwritten by this one
//   busy                  frame in progress
module hist_stats
    import hist_pkg::*;
#(
    parameter int BIN_W = HIST_BIN_W,
    parameter int IDX_W = HIST_IDX_W,
    parameter int SUM_W = BIN_W + IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] bin_count,
    input  logic             bin_valid,
    input  logic             bin_last,
    input  logic             stats_ack,
    output logic             stats_valid,
    output logic [IDX_W-1:0] peak_idx,
    output logic [BIN_W-1:0] peak_count,
    output logic [SUM_W-1:0] total,
    output logic [IDX_W:0]   nonzero_bins,
    output logic             idx_ovf,
    output logic             overrun,
    output logic             busy
);

    localparam logic [IDX_W-1:0] IDX_MAX = '1;
    localparam logic [IDX_W:0]   NZ_MAX  = {1'b1, {IDX_W{1'b0}}};

    // Result record at this instance's widths.
    typedef struct packed {
        logic [IDX_W-1:0] peak_idx;
        logic [BIN_W-1:0] peak_count;
        logic [SUM_W-1:0] total;
        logic [IDX_W:0]   nonzero_bins;
        logic             idx_ovf;
    } res_t;

    hist_state_e      r_state;
    logic [IDX_W-1:0] r_idx;      // index of the most recent accepted bin
    logic             r_ovf;
    logic [SUM_W-1:0] r_total;
    logic [IDX_W:0]   r_nz;
    res_t             r_res;
    logic             r_valid;
    logic             r_overrun;

    logic             w_first;
    logic             w_load;
    logic [IDX_W-1:0] w_idx;
    logic             w_ovf;
    logic [SUM_W-1:0] w_total;
    logic [IDX_W:0]   w_nz;
    logic [SUM_W:0]   w_sum;
    logic [IDX_W-1:0] w_pk_idx;
    logic [BIN_W-1:0] w_pk_cnt;

    // Any beat seen in IDLE opens a frame (possibly a one-bin frame).
    assign w_first = bin_valid && (r_state == ST_IDLE);
    assign w_load  = bin_valid && bin_last;
    assign w_sum   = {1'b0, r_total} + (SUM_W + 1)'(bin_count);

    // Values of the accumulators including the current beat.
    always_comb begin
        w_idx   = r_idx;
        w_ovf   = r_ovf;
        w_total = r_total;
        w_nz    = r_nz;
        if (w_first) begin
            w_idx   = '0;
            w_ovf   = 1'b0;
            w_total = SUM_W'(bin_count);
            w_nz    = (IDX_W + 1)'(bin_count != '0);
        end else begin
            // Index sticks at its maximum; further bins still feed the sums.
            if (r_idx == IDX_MAX) begin
                w_ovf = 1'b1;
            end else begin
                w_idx = r_idx + 1'b1;
            end
            w_total = w_sum[SUM_W] ? '1 : w_sum[SUM_W-1:0];
            if ((bin_count != '0) && (r_nz != NZ_MAX)) begin
                w_nz = r_nz + 1'b1;
            end
        end
    end

    hist_peak_tracker #(
        .BIN_W (BIN_W),
        .IDX_W (IDX_W)
    ) u_peak (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_beat      (bin_valid),
        .i_first     (w_first),
        .i_idx       (w_idx),
        .i_count     (bin_count),
        .o_nxt_idx   (w_pk_idx),
        .o_nxt_count (w_pk_cnt)
    );

    // Frame FSM and accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_ovf   <= 1'b0;
            r_total <= '0;
            r_nz    <= '0;
        end else if (bin_valid) begin
            r_state <= bin_last ? ST_IDLE : ST_ACCUM;
            r_idx   <= w_idx;
            r_ovf   <= w_ovf;
            r_total <= w_total;
            r_nz    <= w_nz;
        end
    end

    // Result register and handshake. A load in the ack cycle counts as a
    // clean hand-off, so overrun only flags a result nobody acknowledged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res     <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_load) begin
            r_res.peak_idx     <= w_pk_idx;
            r_res.peak_count   <= w_pk_cnt;
            r_res.total        <= w_total;
            r_res.nonzero_bins <= w_nz;
            r_res.idx_ovf      <= w_ovf;
            r_valid            <= 1'b1;
            r_overrun          <= r_valid && !stats_ack;
        end else if (stats_ack) begin
            r_valid <= 1'b0;
        end
    end

    assign stats_valid  = r_valid;
    assign peak_idx     = r_res.peak_idx;
    assign peak_count   = r_res.peak_count;
    assign total        = r_res.total;
    assign nonzero_bins = r_res.nonzero_bins;
    assign idx_ovf      = r_res.idx_ovf;
    assign overrun      = r_overrun;
    assign busy         = (r_state == ST_ACCUM);

endmodule
